// File: rtl/seq_det_pkg.sv
// Shared types, reset defaults and helpers for the parametrised sequence detector.
package seq_det_pkg;

  typedef enum logic {
    FILL   = 1'b0,
    SEARCH = 1'b1
  } state_e;

  // Reset configuration: 1011, four bits, overlapping.
  localparam logic [31:0] DFLT_PATTERN = 32'b1011;
  localparam int unsigned DFLT_LEN     = 4;
  localparam logic        DFLT_OVERLAP = 1'b1;

  // A pattern length is usable when it lies in 1..max_len.
  function automatic logic len_in_range(input int unsigned len, input int unsigned max_len);
    return (len >= 1) && (len <= max_len);
  endfunction

endpackage

// File: rtl/seq_det_window.sv
// History shift register plus a length-masked pattern comparator.
// match is combinational and refers to the bit currently on din.
module seq_det_window #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               shift,
  input  logic               clr,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [LEN_W-1:0]   len,
  output logic               match
);

  // The oldest history bit can never be part of a comparison, so it is not stored.
  logic [MAX_LEN-2:0] hist_q;
  logic [MAX_LEN-1:0] cand;
  logic [MAX_LEN-1:0] mask;

  assign cand = {hist_q, din};

  // Keep only the low len bits of the candidate window.
  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
  end

  assign match = (((cand ^ pattern) & mask) == '0);

  // Shift in accepted bits; clearing takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
    end else if (clr) begin
      hist_q <= '0;
    end else if (shift) begin
      hist_q <= cand[MAX_LEN-2:0];
    end
  end

endmodule

// File: rtl/seq_detector_param.sv
// Programmable serial sequence detector (pattern, length, overlap mode).
// Optional match counter built when SEQDET_COUNT_EN is defined.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned        MAX_LEN     = 8,
  parameter int unsigned        LEN_W       = $clog2(MAX_LEN + 1),
  parameter int unsigned        CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(DFLT_PATTERN),
  parameter int unsigned        DEF_LEN     = DFLT_LEN,
  parameter logic               DEF_OVERLAP = DFLT_OVERLAP
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               cnt_clr,
  output logic               seq_det,
  output logic               cfg_err,
  output logic               searching,
  output logic [CNT_W-1:0]   match_count
);

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_nxt;
  logic [MAX_LEN-1:0] pat_q;
  logic [LEN_W-1:0]   len_q;
  logic               ovl_q;
  logic               seq_det_q, cfg_err_q;
  logic               load_ok, accept, win_match, hit, win_clr;

  assign load_ok  = cfg_load && len_in_range(32'(cfg_len), MAX_LEN);
  // Any load cycle, accepted or not, discards the data bit.
  assign accept   = valid && !cfg_load;
  assign fill_nxt = (fill_q >= len_q) ? len_q : fill_q + 1'b1;
  assign hit      = accept && (fill_nxt == len_q) && win_match;
  assign win_clr  = load_ok || (hit && !ovl_q);

  seq_det_window #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_window (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .shift   (accept),
    .clr     (win_clr),
    .pattern (pat_q),
    .len     (len_q),
    .match   (win_match)
  );

  // Next state and fill count.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    if (load_ok) begin
      state_d = FILL;
      fill_d  = '0;
    end else if (accept) begin
      if (hit && !ovl_q) begin
        state_d = FILL;
        fill_d  = '0;
      end else begin
        fill_d = fill_nxt;
        if (fill_nxt == len_q) state_d = SEARCH;
      end
    end
  end

  // FSM state and fill register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Configuration registers, updated only by an in-range load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= DEF_PATTERN;
      len_q <= LEN_W'(DEF_LEN);
      ovl_q <= DEF_OVERLAP;
    end else if (load_ok) begin
      pat_q <= cfg_pattern;
      len_q <= cfg_len;
      ovl_q <= cfg_overlap;
    end
  end

  // Registered one-cycle pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_det_q <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      seq_det_q <= hit;
      cfg_err_q <= cfg_load && !load_ok;
    end
  end

  assign seq_det   = seq_det_q;
  assign cfg_err   = cfg_err_q;
  assign searching = (state_q == SEARCH);

`ifdef SEQDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Saturating count of seq_det pulses; clear beats a coincident pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (seq_det_q && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_count = cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: queue-based reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_seq_detector_param;

  localparam int unsigned MAX_LEN = 8;
  localparam int unsigned LEN_W   = 4;
  localparam int unsigned CNT_W   = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               din, valid, cfg_load, cfg_overlap, cnt_clr;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               seq_det, cfg_err, searching;
  logic [CNT_W-1:0]   match_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: received bits since the last clear, oldest first.
  bit                 bits[$];
  logic [MAX_LEN-1:0] m_pat;
  int                 m_len;
  logic               m_ovl;
  logic               e_det, e_err;
  logic [CNT_W-1:0]   e_cnt;

  always #5 clk = ~clk;

  seq_detector_param dut (
    .clk         (clk),
    .rst         (rst),
    .din         (din),
    .valid       (valid),
    .cfg_load    (cfg_load),
    .cfg_pattern (cfg_pattern),
    .cfg_len     (cfg_len),
    .cfg_overlap (cfg_overlap),
    .cnt_clr     (cnt_clr),
    .seq_det     (seq_det),
    .cfg_err     (cfg_err),
    .searching   (searching),
    .match_count (match_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    bits.delete();
    m_pat = 8'b0000_1011;
    m_len = 4;
    m_ovl = 1'b1;
    e_det = 1'b0;
    e_err = 1'b0;
    e_cnt = '0;
  endtask

  function automatic logic [CNT_W-1:0] exp_count();
`ifdef SEQDET_COUNT_EN
    return e_cnt;
`else
    return '0;
`endif
  endfunction

  task automatic set_idle();
    din         = 1'b0;
    valid       = 1'b0;
    cfg_load    = 1'b0;
    cfg_pattern = '0;
    cfg_len     = '0;
    cfg_overlap = 1'b0;
    cnt_clr     = 1'b0;
  endtask

  // One clock: advance model from the inputs held across the edge, then compare.
  task automatic tick();
    logic n_det, n_err, eq;
    @(posedge clk);
    #1;
    cyc++;
    n_det = 1'b0;
    n_err = 1'b0;
    if (cnt_clr) e_cnt = '0;
    else if (e_det && (e_cnt != '1)) e_cnt = e_cnt + 1'b1;
    if (cfg_load) begin
      if (cfg_len >= 1 && cfg_len <= MAX_LEN) begin
        m_pat = cfg_pattern;
        m_len = int'(cfg_len);
        m_ovl = cfg_overlap;
        bits.delete();
      end else begin
        n_err = 1'b1;
      end
    end else if (valid) begin
      bits.push_back(din);
      if (bits.size() > m_len) void'(bits.pop_front());
      if (bits.size() == m_len) begin
        eq = 1'b1;
        for (int k = 0; k < m_len; k++) begin
          if (bits[k] != m_pat[m_len-1-k]) eq = 1'b0;
        end
        if (eq) begin
          n_det = 1'b1;
          if (!m_ovl) bits.delete();
        end
      end
    end
    e_det = n_det;
    e_err = n_err;
    check("seq_det", seq_det, e_det);
    check("cfg_err", cfg_err, e_err);
    check("searching", searching, bits.size() == m_len);
    check("match_count", match_count, exp_count());
    set_idle();
  endtask

  task automatic send(input logic d);
    din   = d;
    valid = 1'b1;
    tick();
  endtask

  task automatic send_clr(input logic d);
    din     = d;
    valid   = 1'b1;
    cnt_clr = 1'b1;
    tick();
  endtask

  task automatic send_str(input logic [31:0] s, input int n);
    for (int i = n - 1; i >= 0; i--) send(s[i]);
  endtask

  task automatic gap();
    tick();
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ovl,
                      input logic clr);
    cfg_load    = 1'b1;
    cfg_pattern = pat;
    cfg_len     = len;
    cfg_overlap = ovl;
    cnt_clr     = clr;
    tick();
  endtask

  initial begin
    set_idle();
    model_reset();
    rst = 1'b1;
    #3;
    check("rst_seq_det", seq_det, 1'b0);
    check("rst_cfg_err", cfg_err, 1'b0);
    check("rst_searching", searching, 1'b0);
    check("rst_count", match_count, 0);
    @(negedge clk);
    rst = 1'b0;

    // Default config, stream 1011011: pulses after bits 4 and 7.
    send_str(32'b1011, 4);
    check("def_b4", seq_det, 1'b1);
    check("def_b4_search", searching, 1'b1);
    send_str(32'b01, 2);
    check("def_b6", seq_det, 1'b0);
    send(1'b1);
    check("def_b7", seq_det, 1'b1);
    gap();
    check("def_gap", seq_det, 1'b0);
`ifdef SEQDET_COUNT_EN
    check("def_count", match_count, 2);
`endif

    // Non-overlapping 1011: 1011011 gives one pulse, then 10111011 gives two.
    load(8'b0000_1011, 4'd4, 1'b0, 1'b0);
    check("nov_load_search", searching, 1'b0);
    send_str(32'b1011, 4);
    check("nov_b4", seq_det, 1'b1);
    send_str(32'b011, 3);
    check("nov_b7", seq_det, 1'b0);
    send_str(32'b1011, 4);
    check("nov2_b4", seq_det, 1'b1);
    send_str(32'b101, 3);
    check("nov2_b7", seq_det, 1'b0);
    send(1'b1);
    check("nov2_b8", seq_det, 1'b1);

    // Overlapping 11 with don't-care upper pattern bits: 1111 -> 3 back-to-back pulses.
    load(8'hF3, 4'd2, 1'b1, 1'b1);
    send(1'b1);
    check("p11_b1", seq_det, 1'b0);
    send(1'b1);
    check("p11_b2", seq_det, 1'b1);
    send(1'b1);
    check("p11_b3", seq_det, 1'b1);
    send(1'b1);
    check("p11_b4", seq_det, 1'b1);
    gap();
`ifdef SEQDET_COUNT_EN
    check("p11_count", match_count, 3);
`else
    check("p11_count", match_count, 0);
`endif

    // Default pattern with valid gaps: 10 ... 11.
    load(8'b0000_1011, 4'd4, 1'b1, 1'b0);
    send(1'b1);
    send(1'b0);
    gap();
    gap();
    gap();
    check("gap_hold", seq_det, 1'b0);
    send(1'b1);
    check("gap_b3", seq_det, 1'b0);
    send(1'b1);
    check("gap_b4", seq_det, 1'b1);

    // Rejected loads (len 0 and MAX_LEN+1) between bits.
    send(1'b1);
    send(1'b0);
    load(8'hFF, 4'd0, 1'b0, 1'b0);
    check("err_len0", cfg_err, 1'b1);
    send(1'b1);
    check("err_len0_clear", cfg_err, 1'b0);
    load(8'hFF, 4'(MAX_LEN + 1), 1'b0, 1'b0);
    check("err_len9", cfg_err, 1'b1);
    send(1'b1);
    check("err_keep_detect", seq_det, 1'b1);

    // Async reset after 101: the next 1 must not complete the pattern.
    send_str(32'b101, 3);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_det", seq_det, 1'b0);
    check("mid_rst_search", searching, 1'b0);
    check("mid_rst_count", match_count, 0);
    model_reset();
    #2;
    rst = 1'b0;
    send(1'b1);
    check("post_rst_b1", seq_det, 1'b0);
    send_str(32'b011, 3);
    check("post_rst_b4", seq_det, 1'b1);

    // Full-length pattern, then length-1 non-overlap with a clear colliding with a pulse.
    load(8'hA5, 4'd8, 1'b1, 1'b0);
    send_str(32'hA5A5_13A5, 32);
    load(8'h00, 4'd1, 1'b0, 1'b0);
    send_str(32'b0100110, 7);
    send_clr(1'b0);
    send(1'b1);
    gap();
    gap();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
